// File: rtl/hippo_trial_pkg.sv
// Shared trial phase encoding for the hippocampal trial blocks.
// Used by the sequencer, the responder and the movement block.
package hippo_trial_pkg;

    localparam int PHASE_W = 2;

    typedef enum logic [PHASE_W-1:0] {
        IDLE    = 2'd0,
        EXPLORE = 2'd1,
        REPLAY  = 2'd2,
        DONE    = 2'd3
    } phase_t;

endpackage

// File: rtl/trial_timer.sv
// Loadable down-counter with zero flag; holds at zero.
// Times the replay phase of trial_responder.
module trial_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/trial_responder.sv
// Network-side responder of the trial handshake: explore, replay, done.
// Optional macro TRIAL_RESPONDER_REWARD_COUNT_EN adds the reward_cnt port.
module trial_responder
    import hippo_trial_pkg::*;
#(
    parameter int N_OUT         = 4,
    parameter int MAX_STEPS     = 64,
    parameter int REPLAY_CYCLES = 32,
    parameter int ITRIAL_W      = 10,
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                active,
    input  logic [ITRIAL_W-1:0] itrial,
    input  logic [N_OUT-1:0]    out_vec,
    input  logic                break_in,
    output logic                change_invec,
    output logic                finish_replay_phase,
    output logic                rewarded,
    output logic [PHASE_W-1:0]  phase,
    output logic [CNT_W-1:0]    step_cnt,
`ifdef TRIAL_RESPONDER_REWARD_COUNT_EN
    output logic [CNT_W-1:0]    reward_cnt,
`endif
    output logic [ITRIAL_W-1:0] trial_id
);

    localparam int TW = $clog2(REPLAY_CYCLES + 1);
    localparam logic [TW-1:0] RLOAD = TW'(REPLAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(MAX_STEPS);

    phase_t state;
    logic   step;
    logic   limit;
    logic   to_replay;
    logic   t_zero;

    // A step is one cycle with any spike, never past the limit.
    assign step  = (state == EXPLORE) && (|out_vec)
                && (step_cnt != STEP_MAX);
    assign limit = step && (step_cnt == STEP_MAX - 1'b1);
    assign to_replay = (state == EXPLORE) && run && active
                    && (break_in || limit);
    assign phase = state;

    trial_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (to_replay),
        .load_val(RLOAD),
        .dec     (state == REPLAY),
        .zero    (t_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            change_invec        <= 1'b0;
            finish_replay_phase <= 1'b0;
            rewarded            <= 1'b0;
            step_cnt            <= '0;
            trial_id            <= '0;
        end else if (!run) begin
            state               <= IDLE;
            change_invec        <= 1'b0;
            finish_replay_phase <= 1'b0;
            rewarded            <= 1'b0;
            step_cnt            <= '0;
            trial_id            <= '0;
        end else begin
            change_invec        <= 1'b0;
            finish_replay_phase <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (active) begin
                        state    <= EXPLORE;
                        step_cnt <= '0;
                        rewarded <= 1'b0;
                        trial_id <= itrial;
                    end
                end
                EXPLORE: begin
                    if (!active) begin
                        state    <= IDLE;
                        rewarded <= 1'b0;
                    end else begin
                        if (step) begin
                            change_invec <= 1'b1;
                            step_cnt     <= step_cnt + 1'b1;
                        end
                        if (break_in) begin
                            rewarded <= 1'b1;
                            state    <= REPLAY;
                        end else if (limit) begin
                            rewarded <= 1'b0;
                            state    <= REPLAY;
                        end
                    end
                end
                REPLAY: begin
                    if (!active) begin
                        state    <= IDLE;
                        rewarded <= 1'b0;
                    end else if (t_zero) begin
                        state               <= DONE;
                        finish_replay_phase <= 1'b1;
                    end
                end
                DONE: begin
                    if (!active) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRIAL_RESPONDER_REWARD_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reward_cnt <= '0;
        end else if (!run) begin
            reward_cnt <= '0;
        end else if (finish_replay_phase && rewarded
                     && reward_cnt != '1) begin
            reward_cnt <= reward_cnt + 1'b1;
        end
    end
`else
    // Reward counting compiled out; no reward_cnt port.
`endif

endmodule

// File: tb/tb_trial_responder.sv
// Scoreboard bench for trial_responder (default parameters).
// Define TRIAL_RESPONDER_REWARD_COUNT_EN to also cover reward_cnt.
module tb_trial_responder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run;
    logic       active;
    logic [9:0] itrial;
    logic [3:0] out_vec;
    logic       break_in;
    logic       change_invec;
    logic       finish_replay_phase;
    logic       rewarded;
    logic [1:0] phase;
    logic [7:0] step_cnt;
    logic [9:0] trial_id;
`ifdef TRIAL_RESPONDER_REWARD_COUNT_EN
    logic [7:0] reward_cnt;
`endif

    typedef struct {
        logic [31:0] rew;
        logic [31:0] steps;
        logic [31:0] id;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;
    int   rcyc   = 0;

    always #5 clk = ~clk;

    trial_responder dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .run                (run),
        .active             (active),
        .itrial             (itrial),
        .out_vec            (out_vec),
        .break_in           (break_in),
        .change_invec       (change_invec),
        .finish_replay_phase(finish_replay_phase),
        .rewarded           (rewarded),
        .phase              (phase),
        .step_cnt           (step_cnt),
`ifdef TRIAL_RESPONDER_REWARD_COUNT_EN
        .reward_cnt         (reward_cnt),
`endif
        .trial_id           (trial_id)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: counts pulses and replay cycles, checks each finish.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n || phase == 2'd0) begin
                pulses = 0;
                rcyc   = 0;
            end else begin
                if (change_invec) pulses++;
                if (phase == 2'd2) rcyc++;
            end
            if (finish_replay_phase) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_finish: got pulse expected none");
                end else begin
                    e = sbq.pop_front();
                    chk("rewarded", {31'd0, rewarded}, e.rew);
                    chk("step_cnt", {24'd0, step_cnt}, e.steps);
                    chk("trial_id", {22'd0, trial_id}, e.id);
                    chk("pulses", pulses, e.steps);
                    chk("replay_cycles", rcyc, 32);
                    chk("finish_vs_step", {31'd0, change_invec}, 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_trial(input logic [9:0] id);
        itrial = id;
        active = 1'b1;
        tick();
    endtask

    task automatic spikes(input int n, input int gap);
        repeat (n) begin
            out_vec = 4'b0001;
            tick();
            out_vec = 4'b0000;
            repeat (gap) tick();
        end
    endtask

    task automatic brk();
        break_in = 1'b1;
        tick();
        break_in = 1'b0;
    endtask

    task automatic push(input logic [31:0] r, input logic [31:0] s,
                        input logic [31:0] id);
        exp_t e;
        e.rew   = r;
        e.steps = s;
        e.id    = id;
        sbq.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (phase == 2'd3) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_done: got timeout expected DONE");
    endtask

    task automatic end_trial();
        active = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset_n  = 1'b0;
        run      = 1'b0;
        active   = 1'b0;
        itrial   = '0;
        out_vec  = '0;
        break_in = 1'b0;
        #2;
        chk("rst_phase", {30'd0, phase}, 0);
        chk("rst_change", {31'd0, change_invec}, 0);
        chk("rst_finish", {31'd0, finish_replay_phase}, 0);
        chk("rst_step", {24'd0, step_cnt}, 0);
        chk("rst_tid", {22'd0, trial_id}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run     = 1'b1;
        tick();

        // 1: five spaced spikes, then goal
        start_trial(10'h011);
        push(1, 5, 10'h011);
        spikes(5, 2);
        brk();
        wait_done();
        end_trial();

        // 2: spike every cycle, limit reached, extras ignored
        start_trial(10'h022);
        push(0, 64, 10'h022);
        out_vec = 4'b0010;
        repeat (70) tick();
        out_vec = 4'b0000;
        wait_done();
        end_trial();

        // 3a: all bits in one cycle count once
        start_trial(10'h033);
        push(1, 1, 10'h033);
        out_vec = 4'b1111;
        tick();
        out_vec = 4'b0000;
        tick();
        chk("multi_bit_step", {24'd0, step_cnt}, 1);
        brk();
        wait_done();
        end_trial();

        // 3b: break with the 64th step
        start_trial(10'h034);
        push(1, 64, 10'h034);
        out_vec = 4'b0001;
        repeat (63) tick();
        break_in = 1'b1;
        tick();
        out_vec  = 4'b0000;
        break_in = 1'b0;
        wait_done();
        end_trial();

        // 4a: abort in replay, no finish expected
        start_trial(10'h041);
        spikes(1, 0);
        brk();
        repeat (10) tick();
        chk("in_replay", {30'd0, phase}, 2);
        active = 1'b0;
        tick();
        chk("abort_phase", {30'd0, phase}, 0);
        chk("abort_rew", {31'd0, rewarded}, 0);
        repeat (40) tick();

        // 4b: active held after finish
        start_trial(10'h044);
        push(1, 1, 10'h044);
        spikes(1, 0);
        brk();
        wait_done();
        repeat (10) tick();
        chk("hold_done", {30'd0, phase}, 3);
        chk("hold_no_pulse", {31'd0, finish_replay_phase}, 0);
        active = 1'b0;
        tick();
        chk("idle_phase", {30'd0, phase}, 0);
        chk("idle_rew_held", {31'd0, rewarded}, 1);
        chk("idle_step_held", {24'd0, step_cnt}, 1);
        tick();

        // 5a: async reset mid-explore
        start_trial(10'h055);
        spikes(2, 1);
        out_vec = 4'b0001;
        tick();
        chk("pre_rst_change", {31'd0, change_invec}, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_phase", {30'd0, phase}, 0);
        chk("arst_change", {31'd0, change_invec}, 0);
        chk("arst_step", {24'd0, step_cnt}, 0);
        chk("arst_tid", {22'd0, trial_id}, 0);
        out_vec = 4'b0000;
        active  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // 5b: run dropped mid-trial
        start_trial(10'h066);
        spikes(2, 0);
        chk("run_pre_step", {24'd0, step_cnt}, 2);
        run = 1'b0;
        tick();
        chk("run0_phase", {30'd0, phase}, 0);
        chk("run0_step", {24'd0, step_cnt}, 0);
        chk("run0_tid", {22'd0, trial_id}, 0);
        active = 1'b0;
        run    = 1'b1;
        tick();

`ifdef TRIAL_RESPONDER_REWARD_COUNT_EN
        // 6: three rewarded, two failed trials
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        for (int t = 0; t < 3; t++) begin
            start_trial(10'h070 + 10'(t));
            push(1, 1, 10'h070 + t);
            spikes(1, 0);
            brk();
            wait_done();
            end_trial();
        end
        for (int t = 0; t < 2; t++) begin
            start_trial(10'h080 + 10'(t));
            push(0, 64, 10'h080 + t);
            out_vec = 4'b0100;
            repeat (64) tick();
            out_vec = 4'b0000;
            wait_done();
            end_trial();
        end
        chk("reward_cnt", {24'd0, reward_cnt}, 3);
        run = 1'b0;
        tick();
        chk("reward_cnt_clr", {24'd0, reward_cnt}, 0);
        run = 1'b1;
        tick();
`endif

        repeat (3) tick();
        chk("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
